ps2_keycode: RTL and testbench

- Receives PS/2 keyboard frames (scan code set 2) and turns them into the 8-bit HID-style movement keycode consumed by the pacman movement block: 8'h04 A, 8'h07 D, 8'h16 S, 8'h1A W.
- Tracks make and break codes, so keycode holds the most recently pressed movement key while it is held and returns to 8'h00 when that key is released.
- Sits between the board PS/2 pins and the game-logic keycode bus; all outputs are in the Clk domain.

---
 rtl/ps2_keycode.sv | 169 ++++++++++++++++
 tb/tb_ps2_keycode.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ps2_keycode.sv
// PS/2 keyboard receiver (scan code set 2) that tracks make/break codes and
// holds the 8-bit movement keycode for the most recently pressed WASD/arrow key.
module ps2_keycode #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] keycode,
    output logic       key_event,
    output logic       byte_valid,
    output logic [7:0] raw_byte,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync, dat_sync;
    logic          clk_s, dat_s;
    logic          clk_filt, clk_filt_d;
    logic [FW-1:0] filt_cnt;
    logic          sample;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_q;
    logic [TW-1:0] to_cnt;
    logic          timeout, stop_evt, good, err;
    logic          ext_q, brk_q;
    logic          map_vld;
    logic [7:0]    map_val;
    logic          key_wr;
    logic [7:0]    key_nxt;

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];

    // Bus idles high, so every conditioning register resets to 1.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_sync   <= {clk_sync[0], PS2_CLK};
            dat_sync   <= {dat_sync[0], PS2_DAT};
            clk_filt_d <= clk_filt;
            if (clk_s == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_s;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign sample   = clk_filt_d & ~clk_filt;
    assign timeout  = (state_q != IDLE) && !sample && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign stop_evt = sample && (state_q == STOP);
    assign good     = stop_evt && dat_s && (^{shreg, par_q});
    assign err      = (stop_evt && !good) || timeout;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sample && !dat_s)           state_d = DATA;
            DATA:    if (sample && bit_cnt == 3'd7)  state_d = PARITY;
            PARITY:  if (sample)                     state_d = STOP;
            STOP:    if (sample)                     state_d = IDLE;
            default:                                 state_d = IDLE;
        endcase
        if (timeout) state_d = IDLE;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
            par_q   <= 1'b0;
            to_cnt  <= '0;
        end else begin
            if (state_q == IDLE || sample) to_cnt <= '0;
            else                           to_cnt <= to_cnt + 1'b1;
            if (sample) begin
                case (state_q)
                    IDLE:    bit_cnt <= '0;
                    DATA: begin
                        shreg   <= {dat_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY:  par_q <= dat_s;
                    default: ;
                endcase
            end
        end
    end

    // Arrow keys (E0-prefixed) alias WASD; a prefix mismatch never maps.
    always_comb begin
        map_vld = 1'b1;
        map_val = 8'h00;
        case ({ext_q, shreg})
            {1'b0, 8'h1C}, {1'b1, 8'h6B}: map_val = 8'h04;
            {1'b0, 8'h23}, {1'b1, 8'h74}: map_val = 8'h07;
            {1'b0, 8'h1B}, {1'b1, 8'h72}: map_val = 8'h16;
            {1'b0, 8'h1D}, {1'b1, 8'h75}: map_val = 8'h1A;
            default:                      map_vld = 1'b0;
        endcase
    end

    always_comb begin
        key_wr  = 1'b0;
        key_nxt = keycode;
        if (good && map_vld && shreg != 8'hF0 && shreg != 8'hE0) begin
            if (!brk_q) begin
                key_wr  = 1'b1;
                key_nxt = map_val;
            end else if (map_val == keycode) begin
                key_wr  = 1'b1;
                key_nxt = 8'h00;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            keycode    <= 8'h00;
            key_event  <= 1'b0;
            byte_valid <= 1'b0;
            raw_byte   <= 8'h00;
            frame_err  <= 1'b0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            byte_valid <= good;
            frame_err  <= err;
            key_event  <= key_wr;
            if (key_wr) keycode <= key_nxt;
            if (good) begin
                raw_byte <= shreg;
                if (shreg == 8'hF0) begin
                    brk_q <= 1'b1;
                end else if (shreg == 8'hE0) begin
                    ext_q <= 1'b1;
                end else begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end
            end
            if (err) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ps2_keycode.sv
// Scoreboarded bench for ps2_keycode: frames are bit-banged on the PS/2 pins,
// expected bytes/keycodes/errors are queued at drive time and popped on output pulses.
module tb_ps2_keycode;
    localparam int FL   = 4;
    localparam int TO   = 2000;
    localparam int HALF = 20;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DAT = 1'b1;
    logic [7:0] keycode, raw_byte;
    logic       key_event, byte_valid, frame_err;

    int checks = 0;
    int fails  = 0;
    int err_pending = 0;
    logic [7:0] bq[$];
    logic [7:0] kq[$];

    ps2_keycode #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
        .keycode(keycode), .key_event(key_event), .byte_valid(byte_valid),
        .raw_byte(raw_byte), .frame_err(frame_err)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (Reset_n) begin
            if (byte_valid) begin
                if (bq.size() == 0) chk("byte_valid_extra", 32'(byte_valid), 32'd0);
                else                chk("raw_byte", 32'(raw_byte), 32'(bq.pop_front()));
            end
            if (key_event) begin
                if (kq.size() == 0) chk("key_event_extra", 32'(key_event), 32'd0);
                else                chk("keycode", 32'(keycode), 32'(kq.pop_front()));
            end
            if (frame_err) begin
                if (err_pending == 0) chk("frame_err_extra", 32'(frame_err), 32'd0);
                else err_pending--;
            end
        end
    end

    task automatic ps2_bit(input logic b);
        PS2_DAT = b;
        repeat (HALF) @(negedge Clk);
        PS2_CLK = 1'b0;
        repeat (HALF) @(negedge Clk);
        PS2_CLK = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input logic pflip, input logic stop);
        if (!pflip && stop) bq.push_back(b);
        else                err_pending++;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~(^b) ^ pflip);
        ps2_bit(stop);
        PS2_DAT = 1'b1;
        repeat (40) @(negedge Clk);
    endtask

    task automatic good(input logic [7:0] b);
        frame(b, 1'b0, 1'b1);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge Clk);
        #1;
        chk("rst_keycode", 32'(keycode), 32'd0);
        chk("rst_raw_byte", 32'(raw_byte), 32'd0);
        chk("rst_pulses", {29'd0, key_event, byte_valid, frame_err}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (10) @(negedge Clk);

        // make / break of A
        kq.push_back(8'h04); good(8'h1C);
        chk("make_a", 32'(keycode), 32'h04);
        good(8'hF0);
        chk("f0_no_change", 32'(keycode), 32'h04);
        kq.push_back(8'h00); good(8'h1C);
        chk("break_a", 32'(keycode), 32'h00);

        // holding: break of a non-current key leaves keycode alone
        kq.push_back(8'h1A); good(8'h1D);
        kq.push_back(8'h07); good(8'h23);
        good(8'hF0); good(8'h1D);
        chk("hold_d", 32'(keycode), 32'h07);
        good(8'hF0); kq.push_back(8'h00); good(8'h23);
        chk("release_d", 32'(keycode), 32'h00);

        // extended arrows, bare 75, prefix mismatch
        good(8'hE0); kq.push_back(8'h1A); good(8'h75);
        chk("up_arrow", 32'(keycode), 32'h1A);
        good(8'h75);
        good(8'hE0); good(8'h1C);
        chk("ext_mismatch", 32'(keycode), 32'h1A);
        good(8'hE0); good(8'hF0); kq.push_back(8'h00); good(8'h75);
        chk("up_release", 32'(keycode), 32'h00);

        // typematic repeat: each make pulses key_event
        kq.push_back(8'h16); good(8'h1B);
        kq.push_back(8'h16); good(8'h1B);
        chk("repeat_s", 32'(keycode), 32'h16);

        // framing errors; an error also drops a pending break prefix
        frame(8'h1C, 1'b1, 1'b1);
        chk("parity_err_kc", 32'(keycode), 32'h16);
        frame(8'h1C, 1'b0, 1'b0);
        chk("stop_err_kc", 32'(keycode), 32'h16);
        good(8'hF0);
        frame(8'h23, 1'b1, 1'b1);
        kq.push_back(8'h04); good(8'h1C);
        chk("err_clears_brk", 32'(keycode), 32'h04);

        // timeout after 4 data bits
        err_pending++;
        ps2_bit(1'b0);
        ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
        PS2_DAT = 1'b0;
        repeat (HALF) @(negedge Clk);
        PS2_CLK = 1'b0;
        n = 0;
        while (n < TO + 200) begin
            @(negedge Clk);
            n++;
            if (n == HALF) PS2_CLK = 1'b1;
            if (frame_err) break;
        end
        chk("timeout_latency", 32'(n), 32'(FL + 3 + TO));
        PS2_DAT = 1'b1;
        repeat (40) @(negedge Clk);
        kq.push_back(8'h07); good(8'h23);
        chk("after_timeout", 32'(keycode), 32'h07);

        // reset mid-frame
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        Reset_n = 1'b0;
        #1;
        chk("midrst_keycode", 32'(keycode), 32'd0);
        chk("midrst_raw_byte", 32'(raw_byte), 32'd0);
        chk("midrst_pulses", {29'd0, key_event, byte_valid, frame_err}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        PS2_DAT = 1'b1;
        repeat (40) @(negedge Clk);
        kq.push_back(8'h1A); good(8'h1D);
        chk("after_reset", 32'(keycode), 32'h1A);

        repeat (100) @(negedge Clk);
        chk("bytes_left", 32'(bq.size()), 32'd0);
        chk("keys_left", 32'(kq.size()), 32'd0);
        chk("errs_left", 32'(err_pending), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
